// File: rtl/matrix_loader_if.sv
// matrix_loader_if: element stream in (valid/ready/last) and BRAM write port out.
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 8
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif
interface matrix_loader_if #(
    parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic [ELEMENT_WIDTH-1:0] in_data;
    logic                     mem_wr_en;
    logic [ADDR_WIDTH-1:0]    mem_wr_addr;
    logic [ELEMENT_WIDTH-1:0] mem_wr_data;
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/matrix_loader.sv
// matrix_loader: streams m x n elements row-major into BRAM from a base address.
// MATRIX_LOADER_ZERO_FILL_EN: an early in_last zero-fills the rest instead of erroring.
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 8
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif
module matrix_loader #(
    parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH,
    parameter int MAX_DIM       = 5,
    parameter int VALUE_MAX     = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            dim_m,
    input  logic [3:0]            dim_n,
    input  logic [ADDR_WIDTH-1:0] addr_base,
    output logic                  done,
    output logic                  error,
    matrix_loader_if.slave        bus
);
    typedef enum logic [2:0] {IDLE, CHECK, RECV, WRITE, FILL, DONE} state_t;
    localparam logic [3:0]               MAXD = 4'(MAX_DIM);
    localparam logic [ELEMENT_WIDTH-1:0] VMAX = ELEMENT_WIDTH'(VALUE_MAX);
    state_t                   r_state;
    logic [3:0]               r_m, r_n, r_i, r_j;
    logic [ADDR_WIDTH-1:0]    r_addr, r_wr_addr;
    logic [ELEMENT_WIDTH-1:0] r_wr_data;
    logic                     r_last, r_ready, r_wr_en, r_done, r_error;
    logic                     w_accept, w_row_end, w_final;
    assign w_accept  = bus.in_valid & r_ready;
    assign w_row_end = r_j == r_n - 4'd1;
    assign w_final   = w_row_end && r_i == r_m - 4'd1;
    assign bus.in_ready    = r_ready;
    assign bus.mem_wr_en   = r_wr_en;
    assign bus.mem_wr_addr = r_wr_addr;
    assign bus.mem_wr_data = r_wr_data;
    assign done  = r_done;
    assign error = r_error;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_n       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_addr    <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_last    <= 1'b0;
            r_ready   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_m     <= dim_m;
                    r_n     <= dim_n;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_addr  <= addr_base;
                    r_state <= CHECK;
                end
                CHECK: if (r_m == '0 || r_n == '0 || r_m > MAXD || r_n > MAXD) begin
                    r_error <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_ready <= 1'b1;
                    r_state <= RECV;
                end
                RECV: if (w_accept) begin
                    r_ready <= 1'b0;
                    if (bus.in_data > VMAX) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= bus.in_data;
                        r_last    <= bus.in_last;
                        r_state   <= WRITE;
                    end
                end
                // (r_i, r_j) and r_addr track the element being written this cycle
                WRITE, FILL: begin
                    r_j     <= w_row_end ? 4'd0 : r_j + 4'd1;
                    r_i     <= w_row_end ? r_i + 4'd1 : r_i;
                    r_addr  <= r_addr + 1'b1;
                    r_wr_en <= 1'b0;
                    if (w_final) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
`ifdef MATRIX_LOADER_ZERO_FILL_EN
                    else if (r_last) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr + 1'b1;
                        r_wr_data <= '0;
                        r_state   <= FILL;
                    end
`else
                    else if (r_last) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
`endif
                    else begin
                        r_ready <= 1'b1;
                        r_state <= RECV;
                    end
                end
                DONE: if (!start) begin
                    r_done    <= 1'b0;
                    r_error   <= 1'b0;
                    r_wr_addr <= '0;
                    r_wr_data <= '0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed and randomized loads of matrix_loader checked against a behavioural model.
`timescale 1ns/1ps
module tb_matrix_loader;
    localparam int AW = 10;
    localparam int DW = 8;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    dim_m = '0;
    logic [3:0]    dim_n = '0;
    logic [AW-1:0] addr_base = '0;
    logic          done, error;
    int            tests = 0;
    int            fails = 0;
    int            el[32];
    bit            la[32];

    matrix_loader_if #(.ELEMENT_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    matrix_loader #(.ELEMENT_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .dim_m(dim_m), .dim_n(dim_n),
        .addr_base(addr_base), .done(done), .error(error), .bus(bus)
    );

    always #5 clk = ~clk;

    // Expected write log, error flag and start-to-done cycle count from the element rules.
    task automatic model(input int m, input int n, input int base,
                         output string es, output bit eerr, output int ecyc);
        int mn;
        mn = m * n;
        es = "";
        eerr = 1'b1;
        ecyc = 2;
        if (m < 1 || m > 5 || n < 1 || n > 5) return;
        for (int k = 0; k < mn; k++) begin
            if (el[k] > 9) begin
                ecyc = 3 + 2 * k;
                return;
            end
            es = {es, $sformatf("%0h:%0h ", (base + k) % 1024, el[k])};
            if (k == mn - 1) begin
                eerr = 1'b0;
                ecyc = 2 + 2 * mn;
                return;
            end
            if (la[k]) begin
`ifdef MATRIX_LOADER_ZERO_FILL_EN
                for (int f = k + 1; f < mn; f++) es = {es, $sformatf("%0h:%0h ", (base + f) % 1024, 0)};
                eerr = 1'b0;
                ecyc = 2 + 2 * (k + 1) + (mn - k - 1);
`else
                ecyc = 4 + 2 * k;
`endif
                return;
            end
        end
    endtask

    // Drives one load and logs every write; "!" marks a cycle with in_ready and mem_wr_en both high.
    task automatic run_load(input int m, input int n, input int base, input int nel, input bit gaps,
                            output string ws, output bit err, output int cyc, output bit rel_ok);
        int idx;
        bit v;
        idx = 0;
        ws = "";
        err = 1'b0;
        cyc = -1;
        @(negedge clk);
        dim_m = 4'(m);
        dim_n = 4'(n);
        addr_base = AW'(base);
        start = 1'b1;
        for (int c = 1; c <= 400 && cyc < 0; c++) begin
            @(negedge clk);
            if (bus.mem_wr_en) ws = {ws, $sformatf("%0h:%0h ", bus.mem_wr_addr, bus.mem_wr_data)};
            if (bus.mem_wr_en && bus.in_ready) ws = {ws, "! "};
            if (done) begin
                cyc = c;
                err = error;
            end
            v = idx < nel && (!gaps || $urandom_range(0, 2) != 0);
            bus.in_valid = v;
            bus.in_data = DW'(el[idx]);
            bus.in_last = la[idx];
            if (v && bus.in_ready) idx++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                dim_m = 4'($urandom);
                dim_n = 4'($urandom);
                addr_base = AW'($urandom);
            end
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rel_ok = !done && !error;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.in_ready, bus.mem_wr_en, done, error, bus.mem_wr_addr, bus.mem_wr_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b we=%b done=%b err=%b addr=%h data=%h want all 0",
                     bus.in_ready, bus.mem_wr_en, done, error, bus.mem_wr_addr, bus.mem_wr_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        string ws, es;
        bit err, eerr, rel;
        int cyc, ecyc;
        for (int k = 0; k < 32; k++) begin el[k] = k + 1; la[k] = 1'b0; end
        run_load(2, 3, 'h10, 6, 1'b0, ws, err, cyc, rel);
        model(2, 3, 'h10, es, eerr, ecyc);
        tests += 4;
        if (ws != es) begin fails++; $display("FAIL basic_writes: got '%s' want '%s'", ws, es); end
        if (err !== eerr) begin fails++; $display("FAIL basic_error: got %b want %b", err, eerr); end
        if (cyc != 14) begin fails++; $display("FAIL basic_cycles: got %0d want 14", cyc); end
        if (!rel) begin fails++; $display("FAIL basic_release: done/error still set after start dropped"); end
    endtask

    task automatic test_dim_error();
        string ws, es;
        bit err, eerr, rel;
        int cyc, ecyc;
        int dm[4] = '{0, 3, 6, 5};
        int dn[4] = '{3, 6, 2, 0};
        for (int k = 0; k < 32; k++) begin el[k] = k % 10; la[k] = 1'b0; end
        for (int t = 0; t < 4; t++) begin
            run_load(dm[t], dn[t], 'h40, 25, 1'b0, ws, err, cyc, rel);
            model(dm[t], dn[t], 'h40, es, eerr, ecyc);
            tests += 4;
            if (ws != es) begin fails++; $display("FAIL dim_writes %0dx%0d: got '%s' want '%s'", dm[t], dn[t], ws, es); end
            if (err !== 1'b1) begin fails++; $display("FAIL dim_error %0dx%0d: got %b want 1", dm[t], dn[t], err); end
            if (cyc != ecyc) begin fails++; $display("FAIL dim_cycles %0dx%0d: got %0d want %0d", dm[t], dn[t], cyc, ecyc); end
            if (!rel) begin fails++; $display("FAIL dim_release %0dx%0d: done/error still set", dm[t], dn[t]); end
        end
    endtask

    task automatic test_bad_value();
        string ws, es;
        bit err, eerr, rel;
        int cyc, ecyc;
        for (int k = 0; k < 32; k++) begin el[k] = (k % 9) + 1; la[k] = 1'b0; end
        el[3] = 12;
        run_load(3, 3, 'h80, 9, 1'b0, ws, err, cyc, rel);
        model(3, 3, 'h80, es, eerr, ecyc);
        tests += 4;
        if (ws != es) begin fails++; $display("FAIL badval_writes: got '%s' want '%s'", ws, es); end
        if (err !== 1'b1) begin fails++; $display("FAIL badval_error: got %b want 1", err); end
        if (cyc != ecyc) begin fails++; $display("FAIL badval_cycles: got %0d want %0d", cyc, ecyc); end
        if (!rel) begin fails++; $display("FAIL badval_release: done/error still set"); end
    endtask

    task automatic test_early_last();
        string ws, es;
        bit err, eerr, rel;
        int cyc, ecyc;
        for (int k = 0; k < 32; k++) begin el[k] = 0; la[k] = 1'b0; end
        el[0] = 5;
        el[1] = 7;
        la[1] = 1'b1;
        run_load(2, 2, 'h30, 2, 1'b0, ws, err, cyc, rel);
        model(2, 2, 'h30, es, eerr, ecyc);
        tests += 4;
        if (ws != es) begin fails++; $display("FAIL early_last_writes: got '%s' want '%s'", ws, es); end
        if (err !== eerr) begin fails++; $display("FAIL early_last_error: got %b want %b", err, eerr); end
        if (cyc != ecyc) begin fails++; $display("FAIL early_last_cycles: got %0d want %0d", cyc, ecyc); end
        if (!rel) begin fails++; $display("FAIL early_last_release: done/error still set"); end
    endtask

    task automatic test_wrap();
        string ws, es;
        bit err, eerr, rel;
        int cyc, ecyc;
        for (int k = 0; k < 32; k++) begin el[k] = 9 - (k % 10); la[k] = 1'b0; end
        run_load(1, 4, 'h3FE, 4, 1'b0, ws, err, cyc, rel);
        model(1, 4, 'h3FE, es, eerr, ecyc);
        tests += 3;
        if (ws != es) begin fails++; $display("FAIL wrap_writes: got '%s' want '%s'", ws, es); end
        if (err !== 1'b0) begin fails++; $display("FAIL wrap_error: got %b want 0", err); end
        if (cyc != 10) begin fails++; $display("FAIL wrap_cycles: got %0d want 10", cyc); end
    endtask

    task automatic test_random();
        string ws, es;
        bit err, eerr, rel, gaps;
        int cyc, ecyc, m, n, base, nel;
        for (int it = 0; it < 40; it++) begin
            m = $urandom_range(0, 6);
            n = $urandom_range(0, 6);
            base = $urandom_range(0, 1023);
            gaps = 1'($urandom_range(0, 1));
            for (int k = 0; k < 32; k++) begin
                el[k] = ($urandom_range(0, 14) == 0) ? $urandom_range(10, 255) : $urandom_range(0, 9);
                la[k] = $urandom_range(0, 11) == 0;
            end
            nel = (m >= 1 && m <= 5 && n >= 1 && n <= 5) ? m * n : 0;
            run_load(m, n, base, nel, gaps, ws, err, cyc, rel);
            model(m, n, base, es, eerr, ecyc);
            tests += 4;
            if (ws != es) begin fails++; $display("FAIL rand%0d_writes %0dx%0d: got '%s' want '%s'", it, m, n, ws, es); end
            if (err !== eerr) begin fails++; $display("FAIL rand%0d_error: got %b want %b", it, err, eerr); end
            if (cyc < 0 || (!gaps && cyc != ecyc)) begin fails++; $display("FAIL rand%0d_cycles: got %0d want %0d", it, cyc, ecyc); end
            if (!rel) begin fails++; $display("FAIL rand%0d_release: done/error still set", it); end
        end
    endtask

    task automatic test_reset_mid();
        string ws, es;
        bit err, eerr, rel;
        int cyc, ecyc, nw;
        bit hit;
        for (int k = 0; k < 32; k++) begin el[k] = $urandom_range(0, 9); la[k] = 1'b0; end
        nw = 0;
        hit = 1'b0;
        @(negedge clk);
        dim_m = 4'd2;
        dim_n = 4'd2;
        addr_base = AW'('h20);
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = DW'(el[0]);
        bus.in_last = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (bus.mem_wr_en) nw++;
            if (nw == 3) begin
                hit = 1'b1;
                rst = 1'b1;
                start = 1'b0;
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        tests++;
        if (!hit || {bus.in_ready, bus.mem_wr_en, done, error, bus.mem_wr_addr, bus.mem_wr_data} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: reached=%b rdy=%b we=%b done=%b err=%b addr=%h data=%h want all 0",
                     hit, bus.in_ready, bus.mem_wr_en, done, error, bus.mem_wr_addr, bus.mem_wr_data);
        end
        rst = 1'b0;
        run_load(2, 2, 'h50, 4, 1'b0, ws, err, cyc, rel);
        model(2, 2, 'h50, es, eerr, ecyc);
        tests += 3;
        if (ws != es) begin fails++; $display("FAIL midreset_reload_writes: got '%s' want '%s'", ws, es); end
        if (err !== 1'b0) begin fails++; $display("FAIL midreset_reload_error: got %b want 0", err); end
        if (cyc != ecyc) begin fails++; $display("FAIL midreset_reload_cycles: got %0d want %0d", cyc, ecyc); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        test_reset();
        test_basic();
        test_dim_error();
        test_bad_value();
        test_early_last();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
